// File: rtl/serial_complement2_ctrl_pkg.sv
// Shared definitions for the bit-serial two's-complement sequencer:
// state encodings and the default operand width.
package serial_complement2_ctrl_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   // 2'b11 is unused and recovers to S_IDLE on the next edge
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/serial_ha_stage.sv
// Single half-adder stage shared by every bit position of the serial complement.
module serial_ha_stage (
   input  logic x,
   input  logic y,
   output logic carry,
   output logic sum
);

   assign sum   = x ^ y;
   assign carry = x & y;

endmodule

// File: rtl/serial_complement2_ctrl.sv
// Bit-serial two's-complement sequencer: produces {cout, ~a + 1} one bit per cycle, LSB first,
// through a single half-adder stage, with a one-cycle done strobe on completion.
module serial_complement2_ctrl
   import serial_complement2_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   result
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   result_q, result_d;

   logic ha_carry;
   logic ha_sum;

   serial_ha_stage u_ha (
      .x     (~op_q[0]),
      .y     (carry_q),
      .carry (ha_carry),
      .sum   (ha_sum)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = a;
               carry_d = 1'b1;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d   = {ha_sum, acc_q[WIDTH-1:1]};
            op_d    = op_q >> 1;
            carry_d = ha_carry;
            cnt_d   = cnt_q + CW'(1);
            // result only moves here, so partial sums are never visible
            if (cnt_q == CNT_LAST) begin
               result_d = {ha_carry, ha_sum, acc_q[WIDTH-1:1]};
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy   = (state_q == S_RUN) || (state_q == S_DONE);
   assign done   = (state_q == S_DONE);
   assign result = result_q;

endmodule
